pipe_stage: RTL and testbench

Parametrised, elastic pipeline-stage register for the five-stage MIPS datapath, replacing the fixed-width, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data word and a control-signal bundle between stages using a valid/ready handshake. A one-entry skid buffer sustains full throughput with no combinational ready path. The stage supports synchronous flush for branch squash, and zeroes control on bubbles so downstream never sees spurious writes. A saturating counter records backpressure cycles for performance debugging.

---
 rtl/pipe_stage_if.sv | 14 +
 rtl/pipe_stage.sv | 94 +++++++++
 tb/tb_pipe_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle carrying a data word and a control bundle
// between pipeline stages.
interface pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 9
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage.sv
// Elastic pipeline register with a one-entry skid buffer, synchronous flush,
// optional bubble masking of control and a saturating backpressure counter.
module pipe_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 9,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_if.slave      in_if,
  pipe_stage_if.master     out_if,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q,      stall_d;

  logic in_fire;
  logic out_fire;

  assign in_if.ready = ~skid_valid_q;
  assign in_fire     = in_if.valid & ~skid_valid_q;
  assign out_fire    = main_valid_q & out_if.ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || out_fire) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_data_d = in_if.data;
        main_ctrl_d = in_if.ctrl;
      end
    end else if (in_fire) begin
      // Main is stalled: the one word already in flight parks in the skid.
      skid_valid_d = 1'b1;
      skid_data_d  = in_if.data;
      skid_ctrl_d  = in_if.ctrl;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_if.ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      stall_q      <= stall_d;
    end
  end

  assign out_if.valid = main_valid_q;
  assign out_if.data  = main_data_q;
  assign out_if.ctrl  = (ZERO_BUBBLE && !main_valid_q) ? '0 : main_ctrl_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Drives two pipe_stage instances (bubble-masked with a 4-bit counter, and
// unmasked with a 16-bit counter) from one stimulus stream against a queue model.
module tb_pipe_stage;

  logic        clock = 1'b0;
  logic        reset, flush;
  logic        t_valid, t_ordy;
  logic [31:0] t_data;
  logic [8:0]  t_ctrl;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  pipe_stage_if #(.DATA_W(32), .CTRL_W(9)) a_in ();
  pipe_stage_if #(.DATA_W(32), .CTRL_W(9)) a_out ();
  pipe_stage_if #(.DATA_W(32), .CTRL_W(9)) b_in ();
  pipe_stage_if #(.DATA_W(32), .CTRL_W(9)) b_out ();

  assign a_in.valid  = t_valid;
  assign a_in.data   = t_data;
  assign a_in.ctrl   = t_ctrl;
  assign a_out.ready = t_ordy;
  assign b_in.valid  = t_valid;
  assign b_in.data   = t_data;
  assign b_in.ctrl   = t_ctrl;
  assign b_out.ready = t_ordy;

  pipe_stage #(.DATA_W(32), .CTRL_W(9), .ZERO_BUBBLE(1'b1), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_if(a_in), .out_if(a_out), .stall_cnt(cnt_a)
  );

  pipe_stage #(.DATA_W(32), .CTRL_W(9), .ZERO_BUBBLE(1'b0), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_if(b_in), .out_if(b_out), .stall_cnt(cnt_b)
  );

  always #5 clock = ~clock;

  // Reference model: FIFO of up to two {ctrl,data} words, plus the last head
  // word ever held (what an unmasked stage shows while empty).
  logic [40:0] mq[$];
  logic [40:0] m_last;
  int unsigned m_cnt4, m_cnt16;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [40:0] head;
    head = (mq.size() > 0) ? mq[0] : m_last;
    check_eq("a_valid", 64'(a_out.valid), 64'(mq.size() > 0));
    check_eq("b_valid", 64'(b_out.valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      check_eq("a_data", 64'(a_out.data), 64'(head[31:0]));
      check_eq("b_data", 64'(b_out.data), 64'(head[31:0]));
    end
    check_eq("a_ctrl", 64'(a_out.ctrl), (mq.size() > 0) ? 64'(head[40:32]) : 64'd0);
    check_eq("b_ctrl", 64'(b_out.ctrl), 64'(m_last[40:32]));
    check_eq("a_ready", 64'(a_in.ready), 64'(mq.size() < 2));
    check_eq("b_ready", 64'(b_in.ready), 64'(mq.size() < 2));
    check_eq("a_stall", 64'(cnt_a), 64'(m_cnt4));
    check_eq("b_stall", 64'(cnt_b), 64'(m_cnt16));
  endtask

  // One clock: apply inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [8:0] c,
                     input logic ordy, input logic fl, input logic rst);
    bit in_fire, out_fire;
    t_valid = v; t_data = d; t_ctrl = c; t_ordy = ordy; flush = fl; reset = rst;
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_cnt4 = 0;
      m_cnt16 = 0;
    end else begin
      in_fire  = v && (mq.size() < 2);
      out_fire = (mq.size() > 0) && ordy;
      if ((mq.size() > 0) && !ordy) begin
        if (m_cnt4 < 15) m_cnt4++;
        if (m_cnt16 < 65535) m_cnt16++;
      end
      if (fl) mq.delete();
      else begin
        if (out_fire) void'(mq.pop_front());
        if (in_fire) mq.push_back({c, d});
      end
      if (mq.size() > 0) m_last = mq[0];
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  initial begin
    t_valid = 0; t_data = '0; t_ctrl = '0; t_ordy = 1; flush = 0; reset = 1;
    m_last = '0; m_cnt4 = 0; m_cnt16 = 0;
    @(posedge clock); #1;

    // Reset held two cycles with a live input
    cyc(1, 32'hDEADBEEF, 9'h1FF, 1, 0, 1);
    cyc(1, 32'hDEADBEEF, 9'h1FF, 1, 0, 1);
    check_eq("rst_valid", 64'(a_out.valid), 64'd0);
    check_eq("rst_ctrl", 64'(a_out.ctrl), 64'd0);
    check_eq("rst_stall", 64'(cnt_a), 64'd0);
    check_eq("rst_ready", 64'(a_in.ready), 64'd1);

    // Streaming
    cyc(1, 32'h1, 9'h011, 1, 0, 0);
    check_eq("stream1", 64'(a_out.data), 64'h1);
    cyc(1, 32'h2, 9'h022, 1, 0, 0);
    check_eq("stream2", 64'(a_out.data), 64'h2);
    cyc(1, 32'h3, 9'h033, 1, 0, 0);
    check_eq("stream3", 64'(a_out.data), 64'h3);
    cyc(0, 32'h0, 9'h1FF, 1, 0, 0);
    check_eq("bubble_mask", 64'(a_out.ctrl), 64'd0);
    check_eq("bubble_held", 64'(b_out.ctrl), 64'h033);

    // Backpressure: 0xA shown, 0xB into skid, 0xC waits upstream
    cyc(1, 32'hA, 9'h00A, 1, 0, 0);
    cyc(1, 32'hB, 9'h00B, 0, 0, 0);
    check_eq("bp_ready", 64'(a_in.ready), 64'd0);
    cyc(1, 32'hC, 9'h00C, 0, 0, 0);
    cyc(1, 32'hC, 9'h00C, 0, 0, 0);
    check_eq("bp_stall3", 64'(cnt_a), 64'd3);
    check_eq("bp_head", 64'(a_out.data), 64'hA);
    cyc(1, 32'hC, 9'h00C, 1, 0, 0);
    check_eq("rec_B", 64'(a_out.data), 64'hB);
    cyc(1, 32'hC, 9'h00C, 1, 0, 0);
    check_eq("rec_C", 64'(a_out.data), 64'hC);
    cyc(0, 32'h0, 9'h000, 1, 0, 0);

    // Flush with main=5, skid=6 and 7 on the input
    cyc(1, 32'h5, 9'h005, 0, 0, 0);
    cyc(1, 32'h6, 9'h006, 0, 0, 0);
    cyc(1, 32'h7, 9'h007, 0, 1, 0);
    check_eq("fl_valid", 64'(a_out.valid), 64'd0);
    check_eq("fl_ctrl", 64'(a_out.ctrl), 64'd0);
    check_eq("fl_ready", 64'(a_in.ready), 64'd1);
    cyc(0, 32'h0, 9'h000, 1, 0, 0);
    check_eq("fl_gone", 64'(a_out.valid), 64'd0);

    // Saturation of the 4-bit counter
    cyc(1, 32'h9, 9'h009, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 32'h0, 9'h000, 0, 0, 0);
    check_eq("sat15", 64'(cnt_a), 64'd15);
    cyc(0, 32'h0, 9'h000, 0, 1, 0);
    cyc(0, 32'h0, 9'h000, 0, 0, 0);
    check_eq("sat_after_flush", 64'(cnt_a), 64'd15);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom, 9'($urandom),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
